// File: rtl/multiplier8bits_rom_pkg.sv
// Shared definitions for the microcoded 8x8 shift-and-add multiplier:
// state encodings, control-word layout and the last-iteration count.
package multiplier8bits_rom_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CALC   = 2'd1,
        ST_DONE   = 2'd2,
        ST_UNUSED = 2'd3
    } state_t;

    // Control word = {next_state[1:0], load, step, res_we, pronto_next}
    localparam int CW_W        = 6;
    localparam int CW_PRONTO   = 0;
    localparam int CW_RES_WE   = 1;
    localparam int CW_STEP     = 2;
    localparam int CW_LOAD     = 3;
    localparam int CW_NEXT_LSB = 4;
    localparam int CW_NEXT_MSB = 5;

    localparam logic [2:0] ITER_LAST = 3'd7;

    typedef logic [CW_W-1:0] ctrl_word_t;

    // Packs one ROM word so the table reads as named fields.
    function automatic ctrl_word_t make_cw(input state_t ns, input logic load,
                                           input logic step, input logic res_we,
                                           input logic pronto);
        return {ns, load, step, res_we, pronto};
    endfunction

endpackage

// File: rtl/multiplier8bits_ctrl_rom.sv
// Combinational control ROM: 16 words addressed by {state, S, last}.
// Each word gives the next state and the datapath strobes for this cycle.
module multiplier8bits_ctrl_rom
    import multiplier8bits_rom_pkg::*;
(
    input  logic [3:0] i_addr,
    output ctrl_word_t o_word
);

    // Constant lookup table; every address is listed so the ROM is total.
    always_comb begin
        case (i_addr)
            // IDLE: wait for S, then load operands
            4'b00_0_0: o_word = make_cw(ST_IDLE, 1'b0, 1'b0, 1'b0, 1'b0);
            4'b00_0_1: o_word = make_cw(ST_IDLE, 1'b0, 1'b0, 1'b0, 1'b0);
            4'b00_1_0: o_word = make_cw(ST_CALC, 1'b1, 1'b0, 1'b0, 1'b0);
            4'b00_1_1: o_word = make_cw(ST_CALC, 1'b1, 1'b0, 1'b0, 1'b0);
            // CALC: step every cycle, S ignored; on the last step write result
            4'b01_0_0: o_word = make_cw(ST_CALC, 1'b0, 1'b1, 1'b0, 1'b0);
            4'b01_0_1: o_word = make_cw(ST_DONE, 1'b0, 1'b1, 1'b1, 1'b1);
            4'b01_1_0: o_word = make_cw(ST_CALC, 1'b0, 1'b1, 1'b0, 1'b0);
            4'b01_1_1: o_word = make_cw(ST_DONE, 1'b0, 1'b1, 1'b1, 1'b1);
            // DONE: S restarts back-to-back, otherwise return to IDLE
            4'b10_0_0: o_word = make_cw(ST_IDLE, 1'b0, 1'b0, 1'b0, 1'b0);
            4'b10_0_1: o_word = make_cw(ST_IDLE, 1'b0, 1'b0, 1'b0, 1'b0);
            4'b10_1_0: o_word = make_cw(ST_CALC, 1'b1, 1'b0, 1'b0, 1'b0);
            4'b10_1_1: o_word = make_cw(ST_CALC, 1'b1, 1'b0, 1'b0, 1'b0);
            // Unused state code recovers to IDLE
            default:   o_word = make_cw(ST_IDLE, 1'b0, 1'b0, 1'b0, 1'b0);
        endcase
    end

endmodule

// File: rtl/multiplier8bits_rom.sv
// 8x8 unsigned shift-and-add multiplier with a ROM-driven control unit.
// A level start S launches an 8-step operation; PRONTO pulses for one cycle
// when the registered 16-bit result is updated.
module multiplier8bits_rom
    import multiplier8bits_rom_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic [7:0]  w,
    input  logic [7:0]  y,
    input  logic        S,
    output logic [15:0] result,
    output logic        PRONTO
);

    state_t      r_state;
    logic [15:0] r_a;
    logic [7:0]  r_b;
    logic [15:0] r_acc;
    logic [2:0]  r_cnt;
    logic [15:0] r_result;
    logic        r_pronto;

    ctrl_word_t  w_word;
    state_t      w_next_state;
    logic        w_load;
    logic        w_step;
    logic        w_res_we;
    logic        w_pronto_next;
    logic        w_last;
    logic [15:0] w_addend;
    logic [15:0] w_acc_next;

    assign w_last = (r_cnt == ITER_LAST);

    multiplier8bits_ctrl_rom u_ctrl_rom (
        .i_addr ({r_state, S, w_last}),
        .o_word (w_word)
    );

    // Decode the ROM word into next state and strobes.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned, which would infer a latch.
        w_next_state  = ST_IDLE;
        w_load        = 1'b0;
        w_step        = 1'b0;
        w_res_we      = 1'b0;
        w_pronto_next = 1'b0;
        w_next_state  = state_t'(w_word[CW_NEXT_MSB:CW_NEXT_LSB]);
        w_load        = w_word[CW_LOAD];
        w_step        = w_word[CW_STEP];
        w_res_we      = w_word[CW_RES_WE];
        w_pronto_next = w_word[CW_PRONTO];
    end

    assign w_addend   = r_b[0] ? r_a : 16'h0000;
    assign w_acc_next = r_acc + w_addend;

    // State and done-flag registers, loaded straight from the ROM output.
    always_ff @(posedge CLK or negedge RESET) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of statement order.
        if (!RESET) begin
            r_state  <= ST_IDLE;
            r_pronto <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_pronto <= w_pronto_next;
        end
    end

    // Datapath: operand load, shift-and-add step, result capture.
    always_ff @(posedge CLK or negedge RESET) begin
        // NOTE: the whole datapath is reset so an aborted operation leaves
        // no stale partial product behind.
        if (!RESET) begin
            r_a      <= 16'h0000;
            r_b      <= 8'h00;
            r_acc    <= 16'h0000;
            r_cnt    <= 3'd0;
            r_result <= 16'h0000;
        end else begin
            if (w_load) begin
                r_a   <= {8'h00, w};
                r_b   <= y;
                r_acc <= 16'h0000;
                r_cnt <= 3'd0;
            end else if (w_step) begin
                r_a   <= r_a << 1;
                r_b   <= r_b >> 1;
                r_acc <= w_acc_next;
                r_cnt <= r_cnt + 3'd1;
            end
            if (w_res_we) begin
                r_result <= w_acc_next;
            end
        end
    end

    assign result = r_result;
    assign PRONTO = r_pronto;

endmodule

// File: tb/tb_multiplier8bits_rom.sv
// Directed self-checking bench for multiplier8bits_rom with a result scoreboard.
module tb_multiplier8bits_rom;

    logic        CLK;
    logic        RESET;
    logic [7:0]  w;
    logic [7:0]  y;
    logic        S;
    logic [15:0] result;
    logic        PRONTO;

    int          checks;
    int          errors;
    logic [15:0] sb_q [$];
    logic        swap_ops;

    multiplier8bits_rom dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .w      (w),
        .y      (y),
        .S      (S),
        .result (result),
        .PRONTO (PRONTO)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive operands and S at a falling edge; the model product goes to the scoreboard.
    task automatic start_op(input logic [7:0] a, input logic [7:0] b);
        @(negedge CLK);
        w = a;
        y = b;
        S = 1'b1;
        sb_q.push_back(16'(a) * 16'(b));
    endtask

    // Count rising edges from the one that samples S until PRONTO is seen,
    // then compare latency and result against the scoreboard head.
    task automatic wait_done(input string tag, input logic hold);
        int cycles;
        logic [15:0] exp;
        cycles = 0;
        do begin
            @(posedge CLK);
            cycles++;
            @(negedge CLK);
            if (!hold) S = 1'b0;
            if (swap_ops && cycles == 4) begin
                w = 8'd3;
                y = 8'd3;
            end
        end while (!PRONTO && cycles < 40);
        check({tag, "_pronto"}, 32'(PRONTO), 32'd1);
        check({tag, "_latency"}, 32'(cycles), 32'd9);
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            exp = sb_q.pop_front();
            check({tag, "_result"}, 32'(result), 32'(exp));
        end
    endtask

    initial begin
        logic saw_pronto;
        logic [15:0] held;
        checks   = 0;
        errors   = 0;
        swap_ops = 1'b0;
        RESET    = 1'b0;
        w        = 8'd0;
        y        = 8'd0;
        S        = 1'b0;
        repeat (3) @(negedge CLK);
        check("reset_result", 32'(result), 32'd0);
        check("reset_pronto", 32'(PRONTO), 32'd0);
        RESET = 1'b1;

        // Single operations
        start_op(8'd6, 8'd10);    wait_done("op_6x10", 1'b0);
        @(negedge CLK);
        check("pulse_one_cycle", 32'(PRONTO), 32'd0);
        check("result_holds", 32'(result), 32'd60);
        start_op(8'd255, 8'd255); wait_done("op_255x255", 1'b0);
        start_op(8'd0, 8'd200);   wait_done("op_0x200", 1'b0);
        start_op(8'd1, 8'd1);     wait_done("op_1x1", 1'b0);
        @(negedge CLK);

        // S held high: back-to-back operations every 9 cycles
        start_op(8'd6, 8'd10);
        sb_q.push_back(16'd60);
        sb_q.push_back(16'd60);
        wait_done("hold_1", 1'b1);
        wait_done("hold_2", 1'b1);
        wait_done("hold_3", 1'b0);
        @(negedge CLK);

        // Operand change during CALC does not disturb the running op
        swap_ops = 1'b1;
        start_op(8'd6, 8'd10);
        wait_done("swap_first", 1'b0);
        swap_ops = 1'b0;
        S = 1'b1;
        sb_q.push_back(16'd9);
        wait_done("swap_second", 1'b0);
        @(negedge CLK);

        // Reset in the middle of CALC
        w = 8'd100;
        y = 8'd100;
        S = 1'b1;
        @(negedge CLK);
        S = 1'b0;
        repeat (3) @(negedge CLK);
        #1 RESET = 1'b0;
        #1;
        check("abort_result", 32'(result), 32'd0);
        check("abort_pronto", 32'(PRONTO), 32'd0);
        @(negedge CLK);
        RESET = 1'b1;
        saw_pronto = 1'b0;
        repeat (12) begin
            @(negedge CLK);
            saw_pronto = saw_pronto | PRONTO;
        end
        check("abort_no_pronto", 32'(saw_pronto), 32'd0);
        start_op(8'd7, 8'd9);     wait_done("restart_7x9", 1'b0);

        // S=0 after DONE: remain idle, result holds
        held = result;
        saw_pronto = 1'b0;
        repeat (15) begin
            @(negedge CLK);
            saw_pronto = saw_pronto | PRONTO;
        end
        check("idle_no_pronto", 32'(saw_pronto), 32'd0);
        check("idle_result_hold", 32'(result), 32'd63);
        check("idle_result_stable", 32'(result), 32'(held));
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
